// File: rtl/mem_pkg.sv
// Shared definitions for the latency-configurable data memory and its lane logic.
// Holds the access-format codes, the FSM state encoding and the alignment check.
package mem_pkg;

    localparam logic [1:0] FMT_BYTE = 2'b00;
    localparam logic [1:0] FMT_HALF = 2'b01;
    localparam logic [1:0] FMT_WORD = 2'b10;
    localparam logic [1:0] FMT_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Returns 1 when the access cannot be performed: misaligned or reserved format.
    function automatic logic access_err(input logic [1:0] fmt, input logic [1:0] off);
        logic err;
        case (fmt)
            FMT_BYTE: err = 1'b0;
            FMT_HALF: err = off[0];
            FMT_WORD: err = (off != 2'b00);
            default:  err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: byte enables and lane replication for stores,
// lane extraction with sign/zero extension for loads.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  data_format,
    input  logic        data_sign,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Byte enable bit 3 is lane [31:24], which is byte offset 0.
    always_comb begin
        byte_en    = 4'b0000;
        store_word = store_data;
        case (data_format)
            FMT_BYTE: begin
                byte_en    = 4'b1000 >> offset;
                store_word = {4{store_data[7:0]}};
            end
            FMT_HALF: begin
                byte_en    = offset[1] ? 4'b0011 : 4'b1100;
                store_word = {2{store_data[15:0]}};
            end
            FMT_WORD: begin
                byte_en    = 4'b1111;
                store_word = store_data;
            end
            default: begin
                byte_en    = 4'b0000;
                store_word = store_data;
            end
        endcase
    end

    always_comb begin
        load_byte = 8'h00;
        case (offset)
            2'd0:    load_byte = load_word[31:24];
            2'd1:    load_byte = load_word[23:16];
            2'd2:    load_byte = load_word[15:8];
            default: load_byte = load_word[7:0];
        endcase
        load_half = offset[1] ? load_word[15:0] : load_word[31:16];
    end

    always_comb begin
        load_data = 32'h0;
        case (data_format)
            FMT_BYTE: load_data = {{24{data_sign & load_byte[7]}}, load_byte};
            FMT_HALF: load_data = {{16{data_sign & load_half[15]}}, load_half};
            FMT_WORD: load_data = load_word;
            default:  load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory_lat.sv
// Word-organised data RAM behind a req/ready/valid handshake with a fixed,
// parameterised number of wait cycles between acceptance and response.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | ready; a request is latched and the latency timer loaded
//   ST_WAIT | counting down wait cycles; requests ignored
//   ST_RESP | one-cycle valid_o pulse with registered dout_o/err_o
module data_memory_lat
    import mem_pkg::*;
#(
    parameter int    RAM_WIDTH = 32,
    parameter int    RAM_ADD   = 11,
    parameter int    ADDR_W    = RAM_ADD + 2,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 ready_o,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [RAM_WIDTH-1:0] din_i,
    input  logic [1:0]           data_format_i,
    input  logic                 data_sign_i,
    output logic                 valid_o,
    output logic [RAM_WIDTH-1:0] dout_o,
    output logic                 err_o
);

    localparam int         DEPTH    = 2 ** RAM_ADD;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [RAM_WIDTH-1:0] mem [DEPTH];

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic capture;

    logic                 lat_we;
    logic [ADDR_W-1:0]    lat_addr;
    logic [RAM_WIDTH-1:0] lat_din;
    logic [1:0]           lat_fmt;
    logic                 lat_sign;

    logic                 op_we;
    logic [ADDR_W-1:0]    op_addr;
    logic [RAM_WIDTH-1:0] op_din;
    logic [1:0]           op_fmt;
    logic                 op_sign;
    logic                 op_err;
    logic [RAM_ADD-1:0]   op_idx;
    logic                 enter_resp;

    logic [3:0]           byte_en;
    logic [RAM_WIDTH-1:0] store_word;
    logic [RAM_WIDTH-1:0] load_data;
    logic [RAM_WIDTH-1:0] dout_q;
    logic                 err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (req_i) begin
                    capture = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                valid_o = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_din  <= '0;
            lat_fmt  <= FMT_BYTE;
            lat_sign <= 1'b0;
        end else if (capture) begin
            lat_we   <= we_i;
            lat_addr <= addr_i;
            lat_din  <= din_i;
            lat_fmt  <= data_format_i;
            lat_sign <= data_sign_i;
        end
    end

    // With LATENCY=1 the array is accessed on the accept edge itself, so the
    // live request fields are used instead of the not-yet-latched copies.
    always_comb begin
        if (state_q == ST_IDLE) begin
            op_we   = we_i;
            op_addr = addr_i;
            op_din  = din_i;
            op_fmt  = data_format_i;
            op_sign = data_sign_i;
        end else begin
            op_we   = lat_we;
            op_addr = lat_addr;
            op_din  = lat_din;
            op_fmt  = lat_fmt;
            op_sign = lat_sign;
        end
    end

    assign op_err     = access_err(op_fmt, op_addr[1:0]);
    assign op_idx     = op_addr[ADDR_W-1:2];
    assign enter_resp = (state_d == ST_RESP);

    mem_lane_align u_lane_align (
        .offset      (op_addr[1:0]),
        .data_format (op_fmt),
        .data_sign   (op_sign),
        .store_data  (op_din),
        .load_word   (mem[op_idx]),
        .byte_en     (byte_en),
        .store_word  (store_word),
        .load_data   (load_data)
    );

    always_ff @(posedge clk_i) begin
        if (enter_resp && op_we && !op_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[op_idx][8*i +: 8] <= store_word[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dout_q <= '0;
            err_q  <= 1'b0;
        end else if (enter_resp) begin
            err_q  <= op_err;
            dout_q <= (op_err || op_we) ? '0 : load_data;
        end
    end

    assign dout_o = dout_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_data_memory_lat.sv
// Directed scoreboard bench: a LATENCY=3 instance for data/lane/error/reset
// behaviour and a LATENCY=1 instance for back-to-back throughput.
module tb_data_memory_lat;
    import mem_pkg::*;

    localparam int LAT3 = 3;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req = 1'b0, we = 1'b0, sgn = 1'b0;
    logic [12:0] addr = '0;
    logic [31:0] din = '0;
    logic [1:0]  fmt = FMT_WORD;
    logic        rdy, vld, err;
    logic [31:0] dout;

    logic        req1 = 1'b0, we1 = 1'b0, sgn1 = 1'b0;
    logic [12:0] addr1 = '0;
    logic [31:0] din1 = '0;
    logic [1:0]  fmt1 = FMT_WORD;
    logic        rdy1, vld1, err1;
    logic [31:0] dout1;

    int checks = 0;
    int fails  = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    data_memory_lat #(.LATENCY(LAT3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ready_o(rdy), .we_i(we),
        .addr_i(addr), .din_i(din), .data_format_i(fmt), .data_sign_i(sgn),
        .valid_o(vld), .dout_o(dout), .err_o(err)
    );

    data_memory_lat #(.LATENCY(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .ready_o(rdy1), .we_i(we1),
        .addr_i(addr1), .din_i(din1), .data_format_i(fmt1), .data_sign_i(sgn1),
        .valid_o(vld1), .dout_o(dout1), .err_o(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input string tag, input logic w, input logic [12:0] a,
                          input logic [31:0] d, input logic [1:0] f, input logic s,
                          input logic [31:0] exp_d, input logic exp_e);
        int   n;
        logic rdy_bad;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, rdy, 1);
        req = 1'b1; we = w; addr = a; din = d; fmt = f; sgn = s;
        @(posedge clk);
        #1 req = 1'b0;
        sb_q.push_back('{err: exp_e, data: exp_d});
        n = 0;
        rdy_bad = 1'b0;
        while (!vld && n < 20) begin
            @(posedge clk);
            #1 n++;
            if (rdy) rdy_bad = 1'b1;
        end
        check({tag, "_latency"}, n, LAT3);
        check({tag, "_ready_low"}, rdy_bad, 0);
        e = sb_q.pop_front();
        if (vld) begin
            check({tag, "_dout"}, dout, e.data);
            check({tag, "_err"}, err, e.err);
            @(posedge clk);
            #1;
            check({tag, "_valid_pulse"}, vld, 0);
            check({tag, "_dout_hold"}, dout, e.data);
        end else begin
            fails++;
            $display("FAIL %s_timeout observed=no valid expected=valid", tag);
        end
    endtask

    initial begin
        #12;
        check("rst_ready", rdy, 1);
        check("rst_valid", vld, 0);
        check("rst_dout", dout, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        access("st_word",   1'b1, 13'h10, 32'hDEADBEEF, FMT_WORD, 1'b0, 32'h0, 1'b0);
        access("ld_word",   1'b0, 13'h10, 32'h0, FMT_WORD, 1'b0, 32'hDEADBEEF, 1'b0);
        access("ld_sbyte",  1'b0, 13'h11, 32'h0, FMT_BYTE, 1'b1, 32'hFFFFFFAD, 1'b0);
        access("ld_ubyte",  1'b0, 13'h11, 32'h0, FMT_BYTE, 1'b0, 32'h000000AD, 1'b0);
        access("ld_shalf",  1'b0, 13'h12, 32'h0, FMT_HALF, 1'b1, 32'hFFFFBEEF, 1'b0);
        access("ld_uhalf0", 1'b0, 13'h10, 32'h0, FMT_HALF, 1'b0, 32'h0000DEAD, 1'b0);
        access("st_byte3",  1'b1, 13'h13, 32'h0000005A, FMT_BYTE, 1'b0, 32'h0, 1'b0);
        access("ld_merged", 1'b0, 13'h10, 32'h0, FMT_WORD, 1'b0, 32'hDEADBE5A, 1'b0);
        access("ld_half_mis", 1'b0, 13'h11, 32'h0, FMT_HALF, 1'b1, 32'h0, 1'b1);
        access("st_word_mis", 1'b1, 13'h12, 32'h11111111, FMT_WORD, 1'b0, 32'h0, 1'b1);
        access("ld_after_mis", 1'b0, 13'h10, 32'h0, FMT_WORD, 1'b0, 32'hDEADBE5A, 1'b0);
        access("ld_rsvd",   1'b0, 13'h10, 32'h0, FMT_RSVD, 1'b0, 32'h0, 1'b1);
        access("st_byte0",  1'b1, 13'h10, 32'h00000080, FMT_BYTE, 1'b0, 32'h0, 1'b0);
        access("ld_sbyte0", 1'b0, 13'h10, 32'h0, FMT_BYTE, 1'b1, 32'hFFFFFF80, 1'b0);
        access("ld_word2",  1'b0, 13'h10, 32'h0, FMT_WORD, 1'b0, 32'h80ADBE5A, 1'b0);
        access("st_pre20",  1'b1, 13'h20, 32'hCAFEF00D, FMT_WORD, 1'b0, 32'h0, 1'b0);

        // Reset arrives while the store to 0x20 is waiting.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 13'h20; din = 32'h12345678; fmt = FMT_WORD;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ready", rdy, 1);
        check("abort_valid", vld, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 check("abort_no_valid", vld, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        access("ld_after_abort", 1'b0, 13'h20, 32'h0, FMT_WORD, 1'b0, 32'hCAFEF00D, 1'b0);

        // LATENCY=1 with a continuously held request.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 13'h40; din1 = 32'h00000001; fmt1 = FMT_WORD;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("l1_valid", vld1, (i % 2 == 0) ? 1 : 0);
            check("l1_ready", rdy1, (i % 2 == 0) ? 0 : 1);
        end
        we1 = 1'b0;
        @(posedge clk);
        #1 req1 = 1'b0;
        check("l1_ld_valid", vld1, 1);
        check("l1_ld_dout", dout1, 32'h00000001);
        check("l1_ld_err", err1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
